// File: rtl/game_frame_handoff.sv
// rtl/game_frame_handoff.sv - tear-free single-entry snapshot handoff into the displayed VGA frame
//
// Purpose:
//   Game logic offers game_state_t snapshots over a valid/ready handshake.
//   The handoff holds one pending snapshot and copies it into VGA_frame only
//   while the decoder reports blanking. It copies at most once per blanking
//   interval, so active video never sees a partially updated frame.
//
// Ports:
//   clk                  in   system clock (same domain as game_decoder)
//   reset                in   synchronous, active-high
//   game_frame_valid     in   producer offers game_frame this cycle
//   game_frame           in   snapshot from game logic
//   game_frame_ready     out  handshake ready (combinational); transfer = valid & ready
//   VGA_new_frame_ready  in   high = blanking, safe to swap
//   VGA_frame            out  frame displayed by game_decoder (registered)
//   frame_committed      out  one-cycle pulse, asserted while VGA_frame first shows a new commit
//   frame_count          out  number of commits, wraps to 0
//   frames_dropped       out  overwritten snapshots, saturates at all-ones

package game_state_pkg;
  typedef struct packed {
    logic [3:0][3:0] screen;
    logic [7:0]      score;
  } game_state_t;
endpackage

module game_frame_handoff
  import game_state_pkg::*;
#(
  parameter logic OVERWRITE      = 1'b0,
  parameter int   DROP_CNT_BITS  = 8,
  parameter int   FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      game_frame_valid,
  input  game_state_t               game_frame,
  output logic                      game_frame_ready,
  input  logic                      VGA_new_frame_ready,
  output game_state_t               VGA_frame,
  output logic                      frame_committed,
  output logic [FRAME_CNT_BITS-1:0] frame_count,
  output logic [DROP_CNT_BITS-1:0]  frames_dropped
);

  typedef enum logic {
    DONE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        commit;
  logic        transfer;
  logic        overwrite_drop;
  logic        pend_v;
  game_state_t pending;

  // In back-pressure mode ready depends only on the pending flag, so there is
  // no combinational path from the decoder's blanking signal to the producer.
  generate
    if (OVERWRITE) begin : g_ready_overwrite
      assign game_frame_ready = ~reset;
    end else begin : g_ready_backpressure
      assign game_frame_ready = ~pend_v;
    end
  endgenerate

  assign transfer = game_frame_valid & game_frame_ready;

  // A transfer that lands in the same cycle as a commit refills the buffer
  // after the old contents were consumed, so it does not count as a drop.
  assign overwrite_drop = OVERWRITE & transfer & pend_v & ~commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DONE;
    end else begin
      state <= state_next;
    end
  end

  // DONE waits for active video before re-arming, which caps commits at one
  // per blanking interval. ARMED stays armed through an empty blank so a
  // late arrival inside the same blank still gets displayed.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      ARMED: begin
        if (VGA_new_frame_ready && pend_v) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!VGA_new_frame_ready) begin
          state_next = ARMED;
        end
      end
      default: state_next = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v          <= 1'b0;
      pending         <= '0;
      VGA_frame       <= '0;
      frame_committed <= 1'b0;
      frame_count     <= '0;
      frames_dropped  <= '0;
    end else begin
      frame_committed <= commit;

      if (commit) begin
        VGA_frame   <= pending;
        frame_count <= frame_count + FRAME_CNT_BITS'(1);
      end

      // Commit reads the old pending value; a simultaneous transfer overwrites
      // it afterwards and keeps the buffer full.
      if (transfer) begin
        pending <= game_frame;
        pend_v  <= 1'b1;
      end else if (commit) begin
        pend_v  <= 1'b0;
      end

      if (overwrite_drop && (frames_dropped != '1)) begin
        frames_dropped <= frames_dropped + DROP_CNT_BITS'(1);
      end
    end
  end

endmodule
